// File: rtl/mlp_train_sequencer.sv
// Purpose: sequences MLP training over a small sample memory for a host-requested number of epochs.
// Latency: each sample takes SETTLE_CYCLES+1 cycles; the done pulse comes N*S*(SETTLE_CYCLES+1) edges after the start edge.
// Backpressure: none; start is ignored outside IDLE, load_en is ignored while busy, abort returns to IDLE.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   load_en/addr/values/expected write one sample (IDLE/DONE only)
//   start, num_epochs, lr_in     launch a run; epoch count and rate are latched
//   abort                        cancel a run without a done pulse
//   mlp_values/expected/training/lr   drive the MLP datapath
//   busy, done, epoch_count, sample_idx  run status
module mlp_train_sequencer #(
   parameter int INPUTS        = 2,
   parameter int OUTPUTS       = 1,
   parameter int NUM_SAMPLES   = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int EPOCH_W       = 16,
   parameter int DATA_W        = 16,
   localparam int AW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load_en,
   input  logic [AW-1:0]               load_addr,
   input  logic [INPUTS*DATA_W-1:0]    load_values,
   input  logic [OUTPUTS*DATA_W-1:0]   load_expected,
   input  logic                        start,
   input  logic [EPOCH_W-1:0]          num_epochs,
   input  logic [DATA_W-1:0]           lr_in,
   input  logic                        abort,
   output logic [INPUTS*DATA_W-1:0]    mlp_values,
   output logic [OUTPUTS*DATA_W-1:0]   mlp_expected,
   output logic                        mlp_training,
   output logic [DATA_W-1:0]           mlp_lr,
   output logic                        busy,
   output logic                        done,
   output logic [EPOCH_W-1:0]          epoch_count,
   output logic [AW-1:0]               sample_idx
);

   localparam int VW  = INPUTS * DATA_W;
   localparam int EW  = OUTPUTS * DATA_W;
   localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, SETTLE, UPDATE, DONE} state_t;

   state_t             state;
   logic [SCW-1:0]     settle_cnt;
   logic [EPOCH_W-1:0] epochs_q;
   logic [VW+EW-1:0]   mem [NUM_SAMPLES];

   logic               run_state;
   logic               wr_ok;
   logic               last_sample;
   logic [AW-1:0]      nxt_idx;
   logic [AW-1:0]      rd_addr;
   logic [VW+EW-1:0]   rd_word;

   assign run_state   = (state == SETTLE) || (state == UPDATE);
   assign wr_ok       = load_en && !run_state && (int'(load_addr) < NUM_SAMPLES);
   assign last_sample = (sample_idx == AW'(NUM_SAMPLES - 1));
   assign nxt_idx     = last_sample ? '0 : sample_idx + AW'(1);
   // IDLE reads sample 0 for the start edge; UPDATE reads the following sample.
   assign rd_addr     = (state == UPDATE) ? nxt_idx : '0;

   // A write landing on the start edge is forwarded so the run sees the new data.
   always_comb begin
      rd_word = mem[rd_addr];
      if (wr_ok && (load_addr == rd_addr))
         rd_word = {load_values, load_expected};
   end

   // Sample memory is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[load_addr] <= {load_values, load_expected};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         settle_cnt   <= '0;
         epochs_q     <= '0;
         mlp_values   <= '0;
         mlp_expected <= '0;
         mlp_training <= 1'b0;
         mlp_lr       <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         epoch_count  <= '0;
         sample_idx   <= '0;
      end else if (abort && state != IDLE) begin
         // epoch_count is kept so the host can see how far the run got.
         state        <= IDLE;
         settle_cnt   <= '0;
         mlp_training <= 1'b0;
         mlp_lr       <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         sample_idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  epochs_q    <= num_epochs;
                  epoch_count <= '0;
                  sample_idx  <= '0;
                  settle_cnt  <= '0;
                  if (num_epochs == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state        <= SETTLE;
                     busy         <= 1'b1;
                     mlp_lr       <= lr_in;
                     mlp_values   <= rd_word[VW+EW-1:EW];
                     mlp_expected <= rd_word[EW-1:0];
                  end
               end
            end
            SETTLE: begin
               if (settle_cnt == SCW'(SETTLE_CYCLES - 1)) begin
                  state        <= UPDATE;
                  mlp_training <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt + SCW'(1);
               end
            end
            UPDATE: begin
               mlp_training <= 1'b0;
               settle_cnt   <= '0;
               sample_idx   <= nxt_idx;
               if (last_sample)
                  epoch_count <= epoch_count + 1'b1;
               if (last_sample && (epoch_count + 1'b1 == epochs_q)) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  mlp_lr <= '0;
               end else begin
                  state        <= SETTLE;
                  mlp_values   <= rd_word[VW+EW-1:EW];
                  mlp_expected <= rd_word[EW-1:0];
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Purpose: directed self-checking bench for mlp_train_sequencer with the XOR sample set.
// Latency: each run is observed for a fixed window of cycles after its start edge.
// Backpressure: not applicable; the bench drives one event per run.
module tb_mlp_train_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_en;
   logic [1:0]  load_addr;
   logic [31:0] load_values;
   logic [15:0] load_expected;
   logic        start;
   logic [15:0] num_epochs;
   logic [15:0] lr_in;
   logic        abort;
   logic [31:0] mlp_values;
   logic [15:0] mlp_expected;
   logic        mlp_training;
   logic [15:0] mlp_lr;
   logic        busy;
   logic        done;
   logic [15:0] epoch_count;
   logic [1:0]  sample_idx;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] tab_v [4];
   logic [15:0] tab_e [4];

   // results of the last run
   int done_cyc, done_cnt, pulses, busy_seen, bad_gap, val_err;
   logic [15:0] snap_ep;
   logic [1:0]  snap_idx;
   logic        snap_tr, snap_busy, snap_done;
   logic [31:0] snap_v;
   logic [15:0] snap_lr;

   localparam logic [15:0] LR = 16'h0123;

   mlp_train_sequencer dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
      .load_values(load_values), .load_expected(load_expected),
      .start(start), .num_epochs(num_epochs), .lr_in(lr_in), .abort(abort),
      .mlp_values(mlp_values), .mlp_expected(mlp_expected),
      .mlp_training(mlp_training), .mlp_lr(mlp_lr), .busy(busy), .done(done),
      .epoch_count(epoch_count), .sample_idx(sample_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // kind: 0 none, 1 second start, 2 load to addr 0, 3 abort, 4 rst; driven at cycle ev_k
   task automatic run(input int epochs, input int ev_k, input int kind);
      int   since;
      logic prev_busy, prev_tr;
      logic [1:0] prev_idx;
      done_cyc = -1; done_cnt = 0; pulses = 0; busy_seen = 0; bad_gap = 0; val_err = 0;
      since = 0; prev_busy = 1'b0; prev_tr = 1'b0; prev_idx = 2'd0;
      num_epochs = 16'(epochs);
      lr_in      = LR;
      start      = 1'b1;
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) start = 1'b0;
         if (k == ev_k + 1) begin
            snap_ep = epoch_count; snap_idx = sample_idx; snap_tr = mlp_training;
            snap_busy = busy; snap_done = done; snap_v = mlp_values; snap_lr = mlp_lr;
            start = 1'b0; load_en = 1'b0; abort = 1'b0; rst = 1'b0;
         end
         if (busy) begin
            busy_seen++;
            if (!prev_busy || sample_idx != prev_idx) since = 0;
            else since++;
            if (mlp_values !== tab_v[sample_idx] || mlp_expected !== tab_e[sample_idx] ||
                mlp_lr !== LR)
               val_err++;
         end
         if (mlp_training) begin
            pulses++;
            if (since != 2 || prev_tr || !busy) bad_gap++;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = k;
         end
         prev_busy = busy; prev_idx = sample_idx; prev_tr = mlp_training;
         if (k == ev_k) begin
            case (kind)
               1: start = 1'b1;
               2: begin
                  load_en = 1'b1; load_addr = 2'd0;
                  load_values = 32'h7FFF_7FFF; load_expected = 16'h7FFF;
               end
               3: abort = 1'b1;
               4: rst = 1'b1;
               default: ;
            endcase
         end
      end
   endtask

   initial begin
      rst = 1'b1; load_en = 1'b0; load_addr = '0; load_values = '0; load_expected = '0;
      start = 1'b0; num_epochs = '0; lr_in = '0; abort = 1'b0;
      // XOR set: values = {x1, x0}, 1.0 encoded as 0x1000
      for (int i = 0; i < 4; i++) begin
         tab_v[i] = {(i[1] ? 16'h1000 : 16'h0000), (i[0] ? 16'h1000 : 16'h0000)};
         tab_e[i] = (i[0] ^ i[1]) ? 16'h1000 : 16'h0000;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_values",   {32'h0, mlp_values}, 64'h0);
      chk("reset_expected", {48'h0, mlp_expected}, 64'h0);
      chk("reset_ctrl",     {60'h0, mlp_training, busy, done, 1'b0}, 64'h0);
      chk("reset_lr",       {48'h0, mlp_lr}, 64'h0);
      chk("reset_status",   {46'h0, epoch_count, sample_idx}, 64'h0);

      for (int i = 0; i < 4; i++) begin
         load_en = 1'b1; load_addr = 2'(i); load_values = tab_v[i]; load_expected = tab_e[i];
         @(posedge clk);
         #1;
      end
      load_en = 1'b0;

      // 1: three epochs
      run(3, 0, 0);
      chk("t1_done_cycle", 64'(done_cyc), 64'd37);
      chk("t1_done_cnt",   64'(done_cnt), 64'd1);
      chk("t1_pulses",     64'(pulses), 64'd12);
      chk("t1_gap",        64'(bad_gap), 64'd0);
      chk("t1_values",     64'(val_err), 64'd0);
      chk("t1_busy_cyc",   64'(busy_seen), 64'd36);
      chk("t1_epochs",     64'(epoch_count), 64'd3);
      chk("t1_idle_lr",    64'(mlp_lr), 64'd0);

      // 2: zero epochs
      run(0, 0, 0);
      chk("t2_done_cycle", 64'(done_cyc), 64'd1);
      chk("t2_pulses",     64'(pulses), 64'd0);
      chk("t2_busy",       64'(busy_seen), 64'd0);
      chk("t2_epochs",     64'(epoch_count), 64'd0);

      // 3: abort during epoch 2, sample 1
      run(3, 17, 3);
      chk("t3_training",   64'(snap_tr), 64'd0);
      chk("t3_busy",       64'(snap_busy), 64'd0);
      chk("t3_epochs",     64'(snap_ep), 64'd1);
      chk("t3_idx",        64'(snap_idx), 64'd0);
      chk("t3_no_done",    64'(done_cnt), 64'd0);
      chk("t3_pulses",     64'(pulses), 64'd5);

      // 4: load while busy is dropped; sample 0 of epoch 2 is the original
      run(2, 5, 2);
      chk("t4_values",     64'(val_err), 64'd0);
      chk("t4_pulses",     64'(pulses), 64'd8);
      chk("t4_done_cycle", 64'(done_cyc), 64'd25);

      // 5: second start while busy is ignored
      run(3, 10, 1);
      chk("t5_done_cycle", 64'(done_cyc), 64'd37);
      chk("t5_done_cnt",   64'(done_cnt), 64'd1);
      chk("t5_pulses",     64'(pulses), 64'd12);

      // 6: reset during the first UPDATE cycle, then a normal run
      run(3, 3, 4);
      chk("t6_rst_ctrl",   {61'h0, snap_tr, snap_busy, snap_done}, 64'h0);
      chk("t6_rst_vals",   {32'h0, snap_v}, 64'h0);
      chk("t6_rst_lr",     {48'h0, snap_lr}, 64'h0);
      chk("t6_rst_status", {46'h0, snap_ep, snap_idx}, 64'h0);
      chk("t6_no_done",    64'(done_cnt), 64'd0);
      run(3, 0, 0);
      chk("t6_rerun_done", 64'(done_cyc), 64'd37);
      chk("t6_rerun_puls", 64'(pulses), 64'd12);
      chk("t6_rerun_vals", 64'(val_err), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
